// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one AXI-lite UART transmitter between NUM_REQ
// byte-stream requesters. Round-robin arbitration with packet lock: a grant is
// held until the requester's byte with req_last=1. Each byte is written to
// UART_DATA_ADDR and the next one waits for the UART tx_done pulse.
//
// Ports:
//   clk, resetn           clock, synchronous active-low reset
//   req_valid/data/last   per-requester byte stream (byte i at [8i+7:8i])
//   req_ready             one-hot, one-cycle byte-accept pulse
//   m_axi_aw*/w*/b*       AXI-lite write-only master (one write outstanding)
//   tx_done               one-cycle pulse from the UART at end of stop bit
//   grant_id, busy        current/last owner, arbiter not idle
//   err_clr               clears the sticky error flags
//   err_slverr            sticky, a non-OKAY write response was seen
//   err_timeout           sticky, tx_done watchdog expired
//
// Optional feature: define UART_ARB_TIMEOUT_EN to add the tx_done watchdog
// (TIMEOUT_CYCLES). Without it err_timeout is tied low and no counter exists.
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ        = 4,
  parameter logic [11:0] UART_DATA_ADDR = 12'h000
`ifdef UART_ARB_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYCLES = 100000
`endif
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [8*NUM_REQ-1:0]       req_data,
  input  logic [NUM_REQ-1:0]         req_last,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [11:0]                m_axi_awaddr,
  output logic                       m_axi_awvalid,
  input  logic                       m_axi_awready,
  output logic [31:0]                m_axi_wdata,
  output logic [3:0]                 m_axi_wstrb,
  output logic                       m_axi_wvalid,
  input  logic                       m_axi_wready,
  input  logic [1:0]                 m_axi_bresp,
  input  logic                       m_axi_bvalid,
  output logic                       m_axi_bready,
  input  logic                       tx_done,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       busy,
  input  logic                       err_clr,
  output logic                       err_slverr,
  output logic                       err_timeout
);

  localparam int unsigned IW = $clog2(NUM_REQ);
  localparam int unsigned PW = IW + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_CAPTURE, S_ADDR, S_RESP, S_WAIT_TX, S_NEXT
  } state_t;

  state_t             state_q, state_d;
  logic [IW-1:0]      grant_q, grant_d, rr_q, rr_d, grant_inc, pick_idx;
  logic               pick_found;
  logic [PW-1:0]      pick_w;
  logic [NUM_REQ-1:0] ready_q, ready_d;
  logic               aw_q, aw_d, w_q, w_d, b_q, b_d;
  logic [7:0]         byte_q, byte_d, cur_byte;
  logic               last_q, last_d;
  logic               txf_q, txf_d, busy_q, busy_d, slv_q, slv_d;
  logic               tx_seen;

`ifdef UART_ARB_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          to_q, to_d;
`endif

  // First requesting index at or after rr_q, wrapping.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    pick_w     = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      pick_w = PW'(rr_q) + PW'(i);
      if (pick_w >= PW'(NUM_REQ)) pick_w = pick_w - PW'(NUM_REQ);
      if (!pick_found && req_valid[pick_w[IW-1:0]]) begin
        pick_found = 1'b1;
        pick_idx   = pick_w[IW-1:0];
      end
    end
  end

  // Byte lane of the current owner.
  always_comb begin
    cur_byte = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (grant_q == IW'(i)) cur_byte = req_data[8*i +: 8];
    end
  end

  assign grant_inc = (grant_q == IW'(NUM_REQ - 1)) ? '0 : grant_q + IW'(1);
  assign tx_seen   = txf_q | tx_done;

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    rr_d    = rr_q;
    ready_d = '0;
    aw_d    = aw_q;
    w_d     = w_q;
    b_d     = b_q;
    byte_d  = byte_q;
    last_d  = last_q;
    txf_d   = txf_q;
    slv_d   = slv_q;
`ifdef UART_ARB_TIMEOUT_EN
    cnt_d   = cnt_q;
    to_d    = to_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (pick_found) begin
          grant_d = pick_idx;
          ready_d = NUM_REQ'(1) << pick_idx;
          state_d = S_CAPTURE;
        end
      end
      S_NEXT: begin
        // Locked: only the owner can continue.
        if (req_valid[grant_q]) begin
          ready_d = NUM_REQ'(1) << grant_q;
          state_d = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        byte_d  = cur_byte;
        last_d  = req_last[grant_q];
        aw_d    = 1'b1;
        w_d     = 1'b1;
        state_d = S_ADDR;
      end
      S_ADDR: begin
        if (m_axi_awready) aw_d = 1'b0;
        if (m_axi_wready)  w_d  = 1'b0;
        if (!aw_d && !w_d) begin
          b_d     = 1'b1;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (m_axi_bvalid) begin
          b_d = 1'b0;
          if (m_axi_bresp == 2'b00) begin
            state_d = S_WAIT_TX;
          end else begin
            // Byte not sent: no tx_done will come, close the byte now.
            slv_d = 1'b1;
            if (last_q) begin
              state_d = S_IDLE;
              rr_d    = grant_inc;
            end else begin
              state_d = S_NEXT;
            end
          end
        end
      end
      S_WAIT_TX: begin
        if (tx_seen) begin
          if (last_q) begin
            state_d = S_IDLE;
            rr_d    = grant_inc;
          end else begin
            state_d = S_NEXT;
          end
        end
`ifdef UART_ARB_TIMEOUT_EN
        else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
          to_d    = 1'b1;
          state_d = S_IDLE;
          rr_d    = grant_inc;
        end
`endif
      end
      default: state_d = S_IDLE;
    endcase

    // tx_done may arrive early (during ADDR/RESP); hold it until WAIT_TX ends.
    if ((state_q == S_ADDR || state_q == S_RESP || state_q == S_WAIT_TX) && tx_done)
      txf_d = 1'b1;
    if (state_d == S_IDLE || state_d == S_NEXT) txf_d = 1'b0;

`ifdef UART_ARB_TIMEOUT_EN
    if (state_q == S_WAIT_TX) cnt_d = cnt_q + CW'(1);
    if (state_d == S_WAIT_TX && state_q != S_WAIT_TX) cnt_d = '0;
    if (err_clr) to_d = 1'b0;
`endif
    if (err_clr) slv_d = 1'b0;

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      rr_q    <= '0;
      ready_q <= '0;
      aw_q    <= 1'b0;
      w_q     <= 1'b0;
      b_q     <= 1'b0;
      byte_q  <= '0;
      last_q  <= 1'b0;
      txf_q   <= 1'b0;
      busy_q  <= 1'b0;
      slv_q   <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
      cnt_q   <= '0;
      to_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
      ready_q <= ready_d;
      aw_q    <= aw_d;
      w_q     <= w_d;
      b_q     <= b_d;
      byte_q  <= byte_d;
      last_q  <= last_d;
      txf_q   <= txf_d;
      busy_q  <= busy_d;
      slv_q   <= slv_d;
`ifdef UART_ARB_TIMEOUT_EN
      cnt_q   <= cnt_d;
      to_q    <= to_d;
`endif
    end
  end

  assign req_ready     = ready_q;
  assign m_axi_awaddr  = UART_DATA_ADDR;
  assign m_axi_awvalid = aw_q;
  assign m_axi_wdata   = {24'b0, byte_q};
  assign m_axi_wstrb   = 4'b0001;
  assign m_axi_wvalid  = w_q;
  assign m_axi_bready  = b_q;
  assign grant_id      = grant_q;
  assign busy          = busy_q;
  assign err_slverr    = slv_q;
`ifdef UART_ARB_TIMEOUT_EN
  assign err_timeout   = to_q;
`else
  assign err_timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: requester queues, an AXI-lite slave with
// programmable ready latency / response, and a UART tx_done model.
module tb_uart_tx_arbiter;

  localparam int unsigned NR = 4;

  logic            clk;
  logic            resetn;
  logic [NR-1:0]   req_valid;
  logic [8*NR-1:0] req_data;
  logic [NR-1:0]   req_last;
  logic [NR-1:0]   req_ready;
  logic [11:0]     m_axi_awaddr;
  logic            m_axi_awvalid;
  logic            m_axi_awready;
  logic [31:0]     m_axi_wdata;
  logic [3:0]      m_axi_wstrb;
  logic            m_axi_wvalid;
  logic            m_axi_wready;
  logic [1:0]      m_axi_bresp;
  logic            m_axi_bvalid;
  logic            m_axi_bready;
  logic            tx_done;
  logic [1:0]      grant_id;
  logic            busy;
  logic            err_clr;
  logic            err_slverr;
  logic            err_timeout;

  uart_tx_arbiter #(
    .NUM_REQ(NR),
    .UART_DATA_ADDR(12'h000)
`ifdef UART_ARB_TIMEOUT_EN
    ,
    .TIMEOUT_CYCLES(50)
`endif
  ) dut (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last), .req_ready(req_ready),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wvalid(m_axi_wvalid),
    .m_axi_wready(m_axi_wready), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
    .m_axi_bready(m_axi_bready), .tx_done(tx_done), .grant_id(grant_id), .busy(busy),
    .err_clr(err_clr), .err_slverr(err_slverr), .err_timeout(err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Requester byte queues: {last, data}.
  logic [8:0] rq [NR][$];
  bit         pop [NR];
  int         ready_cnt [NR];

  // Slave knobs; tx_mode 0 = tx_done tx_delay cycles after B, 1 = with B, 2 = never.
  int         aw_lat, w_lat, tx_mode, tx_delay;
  logic [1:0] bresp_k;
  bit         aw_acc, w_acc, b_done;
  int         aw_wait, w_wait, tx_cnt, n_aw;

  // Accepted writes, recorded at W acceptance.
  logic [31:0] wr_data [$];
  logic [11:0] wr_addr [$];
  logic [3:0]  wr_strb [$];
  logic [1:0]  wr_gid  [$];

  // Requester model: hold byte until req_ready, then advance.
  initial begin
    req_valid = '0; req_data = '0; req_last = '0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < int'(NR); i++) begin
        if (!resetn) pop[i] = 1'b0;
        if (pop[i] && rq[i].size() > 0) void'(rq[i].pop_front());
        pop[i] = 1'b0;
        if (rq[i].size() > 0) begin
          req_valid[i]         = 1'b1;
          req_data[8*i +: 8]   = rq[i][0][7:0];
          req_last[i]          = rq[i][0][8];
        end else begin
          req_valid[i]         = 1'b0;
          req_data[8*i +: 8]   = 8'h00;
          req_last[i]          = 1'b0;
        end
        if (req_ready[i]) begin
          pop[i] = 1'b1;
          ready_cnt[i]++;
        end
      end
    end
  end

  // AXI-lite slave and UART tx_done model.
  initial begin
    m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 0; m_axi_bresp = 0; tx_done = 0;
    forever begin
      @(negedge clk);
      m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 0; m_axi_bresp = 0; tx_done = 0;
      if (!resetn) begin
        aw_acc = 0; w_acc = 0; b_done = 0; aw_wait = 0; w_wait = 0; tx_cnt = 0;
      end else begin
        if (b_done) begin
          aw_acc = 0; w_acc = 0; b_done = 0; aw_wait = 0; w_wait = 0;
        end
        if (tx_cnt > 0) begin
          tx_cnt--;
          if (tx_cnt == 0) tx_done = 1;
        end
        if (m_axi_awvalid && !aw_acc) begin
          if (aw_wait >= aw_lat) begin
            m_axi_awready = 1; aw_acc = 1; n_aw++;
            wr_addr.push_back(m_axi_awaddr);
          end else aw_wait++;
        end
        if (m_axi_wvalid && !w_acc) begin
          if (w_wait >= w_lat) begin
            m_axi_wready = 1; w_acc = 1;
            wr_data.push_back(m_axi_wdata);
            wr_strb.push_back(m_axi_wstrb);
            wr_gid.push_back(grant_id);
          end else w_wait++;
        end else if (aw_acc && w_acc && !b_done && !m_axi_awvalid && !m_axi_wvalid) begin
          m_axi_bvalid = 1;
          m_axi_bresp  = bresp_k;
          if (m_axi_bready) begin
            b_done = 1;
            if (tx_mode == 1) tx_done = 1;
            else if (tx_mode == 0) tx_cnt = tx_delay;
          end
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic reset_dut();
    resetn = 1'b0;
    err_clr = 1'b0;
    for (int i = 0; i < int'(NR); i++) begin
      rq[i].delete();
      ready_cnt[i] = 0;
    end
    wr_data.delete(); wr_addr.delete(); wr_strb.delete(); wr_gid.delete();
    n_aw = 0; aw_lat = 0; w_lat = 0; tx_mode = 0; tx_delay = 3; bresp_k = 2'b00;
    repeat (3) tick();
    resetn = 1'b1;
    tick();
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n;
    bit done;
    n = 0;
    done = 0;
    while (!done && n < budget) begin
      tick();
      n++;
      done = !busy && rq[0].size() == 0 && rq[1].size() == 0 &&
             rq[2].size() == 0 && rq[3].size() == 0;
    end
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL %s_idle: still busy after %0d cycles (busy=%0b)", name, n, busy);
    end
  endtask

  task automatic test_reset();
    reset_dut();
    resetn = 1'b0;
    tick();
    tick();
    checks++;
    if ({m_axi_awvalid, m_axi_wvalid, m_axi_bready, busy, err_slverr, err_timeout} !== 6'b0) begin
      failures++;
      $display("FAIL reset_ctrl: got %b required 000000",
               {m_axi_awvalid, m_axi_wvalid, m_axi_bready, busy, err_slverr, err_timeout});
    end
    checks++;
    if (req_ready !== 4'b0 || grant_id !== 2'd0) begin
      failures++;
      $display("FAIL reset_grant: req_ready=%b grant_id=%0d required 0000/0", req_ready, grant_id);
    end
    resetn = 1'b1;
    tick();
  endtask

  task automatic test_single_byte();
    int lat;
    reset_dut();
    rq[0].push_back({1'b1, 8'h55});
    lat = 0;
    while (!m_axi_awvalid && lat < 20) begin
      tick();
      lat++;
    end
    // valid driven at first negedge; IDLE->CAPTURE->ADDR: awvalid seen on the 3rd negedge
    checks++;
    if (lat !== 3) begin
      failures++;
      $display("FAIL valid_to_awvalid: got %0d negedges required 3", lat);
    end
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL busy_in_flight: got %b required 1", busy);
    end
    wait_idle(100, "single");
    checks++;
    if (wr_data.size() !== 1) begin
      failures++;
      $display("FAIL single_count: got %0d writes required 1", wr_data.size());
    end else begin
      checks++;
      if ({wr_addr[0], wr_data[0], wr_strb[0], wr_gid[0]} !== {12'h000, 32'h55, 4'b0001, 2'd0}) begin
        failures++;
        $display("FAIL single_write: addr=%h data=%h strb=%b gid=%0d required 000/00000055/0001/0",
                 wr_addr[0], wr_data[0], wr_strb[0], wr_gid[0]);
      end
    end
    checks++;
    if (ready_cnt[0] !== 1) begin
      failures++;
      $display("FAIL single_ready: got %0d pulses required 1", ready_cnt[0]);
    end
  endtask

  task automatic test_round_robin();
    logic [1:0] eg [4] = '{2'd0, 2'd1, 2'd0, 2'd1};
    logic [7:0] ed [4] = '{8'h61, 8'h63, 8'h62, 8'h64};
    reset_dut();
    rq[0].push_back({1'b1, 8'h61}); rq[0].push_back({1'b1, 8'h62});
    rq[1].push_back({1'b1, 8'h63}); rq[1].push_back({1'b1, 8'h64});
    wait_idle(300, "rr");
    checks++;
    if (wr_data.size() !== 4) begin
      failures++;
      $display("FAIL rr_count: got %0d writes required 4", wr_data.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (wr_gid[k] !== eg[k] || wr_data[k] !== {24'b0, ed[k]}) begin
          failures++;
          $display("FAIL rr_order[%0d]: gid=%0d data=%h required gid=%0d data=%h",
                   k, wr_gid[k], wr_data[k], eg[k], ed[k]);
        end
      end
    end
  endtask

  task automatic test_packet_lock();
    logic [1:0] eg [6] = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd2};
    logic [7:0] ed [6] = '{8'h55, 8'h41, 8'h52, 8'h54, 8'h0A, 8'h5A};
    reset_dut();
    for (int k = 0; k < 5; k++) rq[1].push_back({k == 4, ed[k]});
    rq[2].push_back({1'b1, 8'h5A});
    wait_idle(500, "lock");
    checks++;
    if (wr_data.size() !== 6) begin
      failures++;
      $display("FAIL lock_count: got %0d writes required 6", wr_data.size());
    end else begin
      for (int k = 0; k < 6; k++) begin
        checks++;
        if (wr_gid[k] !== eg[k] || wr_data[k] !== {24'b0, ed[k]}) begin
          failures++;
          $display("FAIL lock_order[%0d]: gid=%0d data=%h required gid=%0d data=%h",
                   k, wr_gid[k], wr_data[k], eg[k], ed[k]);
        end
      end
    end
    checks++;
    if (ready_cnt[1] !== 5 || ready_cnt[2] !== 1) begin
      failures++;
      $display("FAIL lock_ready: req1=%0d req2=%0d required 5/1", ready_cnt[1], ready_cnt[2]);
    end
  endtask

  task automatic test_split_handshake();
    int n;
    reset_dut();
    w_lat   = 3;
    tx_mode = 1;
    rq[3].push_back({1'b0, 8'h78});
    rq[3].push_back({1'b1, 8'h79});
    n = 0;
    while (!(m_axi_awvalid && m_axi_wvalid) && n < 20) begin
      tick();
      n++;
    end
    tick();
    checks++;
    if ({m_axi_awvalid, m_axi_wvalid} !== 2'b01) begin
      failures++;
      $display("FAIL split_aw_drop: aw/w=%b required 01", {m_axi_awvalid, m_axi_wvalid});
    end
    wait_idle(200, "split");
    checks++;
    if (n_aw !== 2 || wr_data.size() !== 2) begin
      failures++;
      $display("FAIL split_count: aw=%0d w=%0d required 2/2", n_aw, wr_data.size());
    end else begin
      checks++;
      if (wr_data[0] !== 32'h78 || wr_data[1] !== 32'h79 || wr_gid[1] !== 2'd3) begin
        failures++;
        $display("FAIL split_data: %h %h gid=%0d required 78 79 gid=3",
                 wr_data[0], wr_data[1], wr_gid[1]);
      end
    end
  endtask

  task automatic test_slverr();
    reset_dut();
    bresp_k = 2'b10;
    tx_mode = 2;
    rq[0].push_back({1'b1, 8'h41});
    wait_idle(60, "slverr");
    checks++;
    if (err_slverr !== 1'b1 || wr_data.size() !== 1) begin
      failures++;
      $display("FAIL slverr_set: err=%b writes=%0d required 1/1", err_slverr, wr_data.size());
    end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    checks++;
    if (err_slverr !== 1'b0) begin
      failures++;
      $display("FAIL slverr_clr: got %b required 0", err_slverr);
    end
    bresp_k = 2'b00;
    tx_mode = 0;
    rq[0].push_back({1'b1, 8'h42});
    wait_idle(100, "slverr_after");
    checks++;
    if (err_slverr !== 1'b0 || wr_data.size() !== 2) begin
      failures++;
      $display("FAIL slverr_after: err=%b writes=%0d required 0/2", err_slverr, wr_data.size());
    end
  endtask

  task automatic test_timeout();
`ifdef UART_ARB_TIMEOUT_EN
    int lat;
    reset_dut();
    tx_mode = 2;
    rq[0].push_back({1'b1, 8'h54});
    rq[1].push_back({1'b1, 8'h56});
    lat = 0;
    while (!err_timeout && lat < 200) begin
      tick();
      lat++;
    end
    // B on 4th negedge -> WAIT_TX; 50 WAIT_TX cycles later the flag is seen on negedge 55
    checks++;
    if (lat !== 55) begin
      failures++;
      $display("FAIL timeout_latency: got %0d negedges required 55", lat);
    end
    tx_mode = 0;
    wait_idle(200, "timeout");
    checks++;
    if (wr_data.size() !== 2 || err_timeout !== 1'b1) begin
      failures++;
      $display("FAIL timeout_serve: writes=%0d err=%b required 2/1", wr_data.size(), err_timeout);
    end else begin
      checks++;
      if (wr_gid[0] !== 2'd0 || wr_gid[1] !== 2'd1) begin
        failures++;
        $display("FAIL timeout_order: %0d %0d required 0 1", wr_gid[0], wr_gid[1]);
      end
    end
`else
    checks++;
    if (err_timeout !== 1'b0) begin
      failures++;
      $display("FAIL timeout_tied_low: got %b required 0", err_timeout);
    end
`endif
  endtask

  task automatic test_reset_mid_addr();
    int n;
    reset_dut();
    aw_lat = 10;
    w_lat  = 10;
    rq[2].push_back({1'b1, 8'h52});
    n = 0;
    while (!m_axi_awvalid && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (m_axi_awvalid !== 1'b1 || m_axi_wvalid !== 1'b1) begin
      failures++;
      $display("FAIL mid_addr_reach: aw/w=%b required 11", {m_axi_awvalid, m_axi_wvalid});
    end
    resetn = 1'b0;
    rq[2].delete();
    tick();
    checks++;
    if ({m_axi_awvalid, m_axi_wvalid, busy, req_ready} !== 7'b0) begin
      failures++;
      $display("FAIL mid_addr_reset: aw/w/busy/ready=%b required 0000000",
               {m_axi_awvalid, m_axi_wvalid, busy, req_ready});
    end
    reset_dut();
  endtask

  initial begin
    resetn = 1'b0;
    err_clr = 1'b0;
    for (int i = 0; i < int'(NR); i++) begin
      pop[i] = 1'b0;
      ready_cnt[i] = 0;
    end
    aw_acc = 0; w_acc = 0; b_done = 0; aw_wait = 0; w_wait = 0; tx_cnt = 0; n_aw = 0;
    aw_lat = 0; w_lat = 0; tx_mode = 0; tx_delay = 3; bresp_k = 2'b00;
    test_reset();
    test_single_byte();
    test_round_robin();
    test_packet_lock();
    test_split_handshake();
    test_slverr();
    test_timeout();
    test_reset_mid_addr();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
